// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial memory controller.
// Size/owner encodings, latched request record and address/size decode.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] wdata;
    logic [2:0]  len;
    owner_e      own;
  } req_t;

  // The top two address bits of the RAM window select the HCI I/O region.
  function automatic logic is_io(input logic [31:0] addr, input int unsigned aw);
    return ((addr >> (aw - 1)) & 32'd3) == 32'd3;
  endfunction

  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates IF/LSU onto a byte bus; reads finish N+2 cycles after acceptance, writes N+1.
// rdy_in low freezes and rewinds reads; I/O writes wait while io_buffer_full is high.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned RAM_ADDR_WIDTH = 17
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);

  state_e      state_q;
  req_t        req_q;
  logic [2:0]  idx_q;
  logic [2:0]  cap_q;
  logic        pend_q;
  logic [31:0] buf_q;
  logic        if_done_q;
  logic        ls_done_q;
  logic [31:0] if_data_q;
  logic [31:0] ls_rdata_q;

  logic [31:0] cur_addr;
  logic        rd_issue;
  logic        io_block;
  logic        wr_go;
  logic        ls_take;
  logic        if_take;
  logic [31:0] buf_d;
  logic [2:0]  cap_d;

  assign cur_addr = req_q.base + {29'd0, idx_q};
  assign rd_issue = (state_q == READ) && (idx_q < req_q.len);
  assign io_block = is_io(cur_addr, RAM_ADDR_WIDTH) && io_buffer_full;
  assign wr_go    = (state_q == WRITE) && rdy_in && !io_block;

  // A requester may still hold req during its done cycle; that cycle must not re-trigger.
  assign ls_take = ls_req && !ls_done_q;
  assign if_take = if_req && !if_done_q;

  assign mem_a    = (rd_issue || state_q == WRITE) ? cur_addr : 32'd0;
  assign mem_wr   = wr_go;
  assign mem_dout = (state_q == WRITE) ? req_q.wdata[{idx_q[1:0], 3'b000} +: 8] : 8'h00;

  // mem_din is trustworthy only when its address went out last cycle with the bus granted.
  always_comb begin
    buf_d = buf_q;
    if (pend_q) begin
      buf_d[{cap_q[1:0], 3'b000} +: 8] = mem_din;
    end
    cap_d = cap_q + {2'b00, pend_q};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      req_q      <= '0;
      idx_q      <= 3'd0;
      cap_q      <= 3'd0;
      pend_q     <= 1'b0;
      buf_q      <= 32'd0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= 32'd0;
      ls_rdata_q <= 32'd0;
    end else begin
      if (rdy_in) begin
        if_done_q <= 1'b0;
        ls_done_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (rdy_in && !clear_in && (ls_take || if_take)) begin
            idx_q  <= 3'd0;
            cap_q  <= 3'd0;
            pend_q <= 1'b0;
            buf_q  <= 32'd0;
            if (ls_take) begin
              req_q.base  <= ls_addr;
              req_q.wdata <= ls_wdata;
              req_q.len   <= size_to_len(ls_size);
              req_q.own   <= OWN_LS;
              state_q     <= ls_we ? WRITE : READ;
            end else begin
              req_q.base  <= if_addr;
              req_q.wdata <= 32'd0;
              req_q.len   <= 3'd4;
              req_q.own   <= OWN_IF;
              state_q     <= READ;
            end
          end
        end
        READ: begin
          if (clear_in) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
          end else begin
            buf_q <= buf_d;
            cap_q <= cap_d;
            if (!rdy_in) begin
              // The address issued during a stall is lost; resume at the oldest missing byte.
              pend_q <= 1'b0;
              idx_q  <= cap_d;
            end else if (cap_d == req_q.len) begin
              state_q <= IDLE;
              pend_q  <= 1'b0;
              if (req_q.own == OWN_LS) begin
                ls_done_q  <= 1'b1;
                ls_rdata_q <= buf_d;
              end else begin
                if_done_q <= 1'b1;
                if_data_q <= buf_d;
              end
            end else if (rd_issue) begin
              idx_q  <= idx_q + 3'd1;
              pend_q <= 1'b1;
            end else begin
              pend_q <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (wr_go) begin
            if (idx_q + 3'd1 == req_q.len) begin
              state_q   <= IDLE;
              ls_done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a one-cycle-latency byte RAM on the bus.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_in;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [1:0]  ls_size;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;

  int checks   = 0;
  int failures = 0;

  mem_ctrl #(.RAM_ADDR_WIDTH(17)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0]  ram [logic [31:0]];
  logic [31:0] bus_a_s;
  logic        bus_wr_s;
  logic [7:0]  bus_d_s;

  always @(negedge clk_in) begin
    bus_a_s  = mem_a;
    bus_wr_s = mem_wr;
    bus_d_s  = mem_dout;
  end

  always @(posedge clk_in) begin
    mem_din <= ram.exists(bus_a_s) ? ram[bus_a_s] : 8'h00;
    if (bus_wr_s) ram[bus_a_s] = bus_d_s;
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic smp();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] st_a [4];
  logic [7:0]  st_d [4];

  initial begin
    st_a[0] = 32'h0001_FFFE; st_d[0] = 8'hD4;
    st_a[1] = 32'h0001_FFFF; st_d[1] = 8'hC3;
    st_a[2] = 32'h0002_0000; st_d[2] = 8'hB2;
    st_a[3] = 32'h0002_0001; st_d[3] = 8'hA1;

    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    ram[32'h104] = 8'h93; ram[32'h105] = 8'h85; ram[32'h106] = 8'h15; ram[32'h107] = 8'h00;
    ram[32'h200] = 8'hFF;

    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'd0; ls_size = 2'd0; ls_wdata = 32'd0;
    bus_a_s = 32'd0; bus_wr_s = 1'b0; bus_d_s = 8'd0;

    cyc(); cyc(); smp();
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_done", {30'd0, if_done, ls_done}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    cyc(); rst_in = 1'b0;

    // Word fetch at 0x100
    cyc(); if_req = 1'b1; if_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      cyc(); smp();
      chk("fetch_addr", mem_a, 32'h100 + k);
      chk("fetch_nodone", {31'd0, if_done}, 32'd0);
    end
    cyc(); smp();
    chk("fetch_t5_nodone", {31'd0, if_done}, 32'd0);
    cyc(); if_req = 1'b0; smp();
    chk("fetch_t6_done", {31'd0, if_done}, 32'd1);
    chk("fetch_data", if_data, 32'h0000_0513);
    chk("fetch_idle_a", mem_a, 32'd0);
    cyc(); smp();
    chk("fetch_pulse", {31'd0, if_done}, 32'd0);
    chk("fetch_hold", if_data, 32'h0000_0513);

    // Simultaneous requests: byte load wins
    cyc(); if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200; ls_size = 2'd0;
    cyc(); smp();
    chk("arb_ls_first", mem_a, 32'h200);
    cyc(); smp();
    chk("arb_t2_nodone", {31'd0, ls_done}, 32'd0);
    cyc(); ls_req = 1'b0; smp();
    chk("arb_ls_done", {30'd0, if_done, ls_done}, 32'd1);
    chk("arb_ls_rdata", ls_rdata, 32'h0000_00FF);
    cyc(); smp();
    chk("arb_fetch_start", mem_a, 32'h100);
    for (int k = 0; k < 5; k++) cyc();
    if_req = 1'b0; smp();
    chk("arb_fetch_done", {31'd0, if_done}, 32'd1);
    chk("arb_fetch_data", if_data, 32'h0000_0513);
    chk("arb_ls_hold", ls_rdata, 32'h0000_00FF);

    // Word store across 0x20000; io_buffer_full must not matter in RAM space
    cyc(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0001_FFFE; ls_size = 2'd2;
    ls_wdata = 32'hA1B2_C3D4; io_buffer_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(); smp();
      chk("st_wr", {31'd0, mem_wr}, 32'd1);
      chk("st_addr", mem_a, st_a[k]);
      chk("st_data", {24'd0, mem_dout}, {24'd0, st_d[k]});
    end
    cyc(); ls_req = 1'b0; ls_we = 1'b0; io_buffer_full = 1'b0; smp();
    chk("st_done", {31'd0, ls_done}, 32'd1);
    chk("st_wr_off", {31'd0, mem_wr}, 32'd0);
    chk("st_rdata_kept", ls_rdata, 32'h0000_00FF);
    chk("st_ram", {ram[32'h0002_0001], ram[32'h0002_0000], ram[32'h0001_FFFF], ram[32'h0001_FFFE]},
        32'hA1B2_C3D4);

    // I/O byte store held off by io_buffer_full
    cyc(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0003_0000; ls_size = 2'd0;
    ls_wdata = 32'h0000_005A; io_buffer_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(); smp();
      chk("io_blocked", {31'd0, mem_wr}, 32'd0);
      chk("io_addr", mem_a, 32'h0003_0000);
      chk("io_nodone", {31'd0, ls_done}, 32'd0);
    end
    cyc(); io_buffer_full = 1'b0; smp();
    chk("io_write", {31'd0, mem_wr}, 32'd1);
    chk("io_data", {24'd0, mem_dout}, 32'h0000_005A);
    cyc(); ls_req = 1'b0; ls_we = 1'b0; smp();
    chk("io_done", {31'd0, ls_done}, 32'd1);
    chk("io_wr_off", {31'd0, mem_wr}, 32'd0);

    // rdy_in low for two cycles from T+2 of a fetch
    cyc(); if_req = 1'b1; if_addr = 32'h104;
    cyc(); smp();
    chk("stall_a0", mem_a, 32'h104);
    cyc(); rdy_in = 1'b0;
    cyc();
    cyc(); rdy_in = 1'b1; smp();
    chk("stall_reissue", mem_a, 32'h105);
    cyc(); smp();
    chk("stall_a2", mem_a, 32'h106);
    cyc(); smp();
    chk("stall_a3", mem_a, 32'h107);
    chk("stall_t6_nodone", {31'd0, if_done}, 32'd0);
    cyc(); smp();
    chk("stall_t7_nodone", {31'd0, if_done}, 32'd0);
    cyc(); if_req = 1'b0; smp();
    chk("stall_done", {31'd0, if_done}, 32'd1);
    chk("stall_data", if_data, 32'h0015_8593);

    // clear_in at T+3 aborts the fetch
    cyc(); if_req = 1'b1; if_addr = 32'h100;
    cyc();
    cyc();
    cyc(); clear_in = 1'b1; if_req = 1'b0;
    cyc(); clear_in = 1'b0;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200; ls_size = 2'd0; smp();
    chk("clr_no_done", {31'd0, if_done}, 32'd0);
    chk("clr_idle", mem_a, 32'd0);
    cyc(); smp();
    chk("clr_ls_accepted", mem_a, 32'h200);
    chk("clr_no_done2", {31'd0, if_done}, 32'd0);
    cyc();
    cyc(); ls_req = 1'b0; smp();
    chk("clr_ls_done", {31'd0, ls_done}, 32'd1);
    chk("clr_ifdata_kept", if_data, 32'h0015_8593);

    // clear_in in IDLE blocks acceptance; then a zero-extended half load
    cyc(); clear_in = 1'b1; ls_req = 1'b1; ls_addr = 32'h100; ls_size = 2'd1;
    cyc(); clear_in = 1'b0; smp();
    chk("clr_idle_block", mem_a, 32'd0);
    cyc(); smp();
    chk("half_a0", mem_a, 32'h100);
    cyc(); smp();
    chk("half_a1", mem_a, 32'h101);
    cyc(); smp();
    chk("half_t4_nodone", {31'd0, ls_done}, 32'd0);
    cyc(); ls_req = 1'b0; smp();
    chk("half_done", {31'd0, ls_done}, 32'd1);
    chk("half_rdata", ls_rdata, 32'h0000_0513);

    cyc(); cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
